dm_arbiter: RTL and testbench

//  Two-requester arbiter sharing the single-port data memory between the CPU MEM stage (port 0) and a DMA/debug master (port 1).
//  - Grants one access per cycle.
//  - Drives the DM read/write/address/data controls.
//  - Routes the registered DM read data back to the owner with a valid strobe.
//  - Port 1 may lock the memory for multi-beat bursts, bounded by a lock timeout.

---
 rtl/dm_arbiter_if.sv | 49 ++++
 rtl/dm_arbiter.sv | 152 +++++++++++++++
 tb/tb_dm_arbiter.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_arbiter_if.sv
// Data-memory sharing bundle: CPU port 0, DMA/debug port 1,
// the DM control/data lines and the shared read-return path.
interface dm_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 14
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_gnt;
    logic              p0_rvalid;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_lock;
    logic              p1_gnt;
    logic              p1_rvalid;

    logic [DATA_W-1:0] rdata;

    logic              dm_read;
    logic              dm_write;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_in;
    logic [DATA_W-1:0] dm_out;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata, p1_lock,
        input  dm_out,
        output p0_gnt, p0_rvalid,
        output p1_gnt, p1_rvalid,
        output rdata,
        output dm_read, dm_write, dm_addr, dm_in
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata, p1_lock,
        output dm_out,
        input  p0_gnt, p0_rvalid,
        input  p1_gnt, p1_rvalid,
        input  rdata,
        input  dm_read, dm_write, dm_addr, dm_in
    );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port data-memory arbiter with port-1 burst lock and lock timeout.
// Define DM_ARB_RR_EN for round-robin conflicts; default is port-0 fixed priority.
module dm_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 14,
    parameter int MAX_LOCK = 16
) (
    input  logic         clk,
    input  logic         rst,
    dm_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(MAX_LOCK);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LAST0 = 2'd1,
        LAST1 = 2'd2,
        LOCK1 = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_lock_cnt;
    logic [CNT_W-1:0]  w_lock_cnt_nxt;
    logic              r_p0_rvalid;
    logic              r_p1_rvalid;

    logic              w_p0_req;
    logic              w_p1_req;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_timeout;
    logic              w_rr_p1;
    logic              w_rd0;
    logic              w_rd1;
    logic              w_wr0;
    logic              w_wr1;

    assign w_p0_req  = bus.p0_req;
    assign w_p1_req  = bus.p1_req;
    assign w_timeout = (r_lock_cnt == LOCK_MAX);

`ifdef DM_ARB_RR_EN
    // Port 1 wins a conflict only when port 0 owned the memory last.
    assign w_rr_p1 = (r_state == LAST0);
`else
    assign w_rr_p1 = 1'b0;
`endif

    // Grant selection; reset holds both grants low.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst) begin
            if (r_state == LOCK1) begin
                if (w_timeout && w_p0_req) begin
                    w_gnt0 = 1'b1;
                end else if (w_p1_req) begin
                    w_gnt1 = 1'b1;
                end else begin
                    w_gnt0 = w_p0_req;
                end
            end else if (w_p0_req && w_p1_req) begin
                w_gnt0 = ~w_rr_p1;
                w_gnt1 = w_rr_p1;
            end else begin
                w_gnt0 = w_p0_req;
                w_gnt1 = w_p1_req;
            end
        end
    end

    // State tracks the last owner; LOCK1 also counts locked beats.
    always_comb begin
        w_state_nxt    = r_state;
        w_lock_cnt_nxt = r_lock_cnt;
        unique case (1'b1)
            w_gnt0: begin
                w_state_nxt    = LAST0;
                w_lock_cnt_nxt = '0;
            end
            w_gnt1: begin
                if (bus.p1_lock) begin
                    w_state_nxt = LOCK1;
                    if (r_state != LOCK1) begin
                        w_lock_cnt_nxt = CNT_W'(1);
                    end else if (!w_timeout) begin
                        w_lock_cnt_nxt = r_lock_cnt + 1'b1;
                    end
                end else begin
                    w_state_nxt    = LAST1;
                    w_lock_cnt_nxt = '0;
                end
            end
            default: begin
                if (r_state == LOCK1) begin
                    w_state_nxt    = LAST1;
                    w_lock_cnt_nxt = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end

    assign w_rd0 = w_gnt0 & ~bus.p0_we;
    assign w_rd1 = w_gnt1 & ~bus.p1_we;
    assign w_wr0 = w_gnt0 &  bus.p0_we;
    assign w_wr1 = w_gnt1 &  bus.p1_we;

    // DM read data lands one cycle after the grant edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p0_rvalid <= 1'b0;
            r_p1_rvalid <= 1'b0;
        end else begin
            r_p0_rvalid <= w_rd0;
            r_p1_rvalid <= w_rd1;
        end
    end

    always_comb begin
        bus.dm_addr = '0;
        bus.dm_in   = '0;
        if (w_gnt0) begin
            bus.dm_addr = bus.p0_addr;
            bus.dm_in   = bus.p0_wdata;
        end else if (w_gnt1) begin
            bus.dm_addr = bus.p1_addr;
            bus.dm_in   = bus.p1_wdata;
        end
    end

    assign bus.dm_read   = w_rd0 | w_rd1;
    assign bus.dm_write  = w_wr0 | w_wr1;
    assign bus.p0_gnt    = w_gnt0;
    assign bus.p1_gnt    = w_gnt1;
    assign bus.p0_rvalid = r_p0_rvalid;
    assign bus.p1_rvalid = r_p1_rvalid;
    assign bus.rdata     = bus.dm_out;

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: DM model, read-return queues,
// priority, lock timeout/saturation/release and async reset.
module tb_dm_arbiter;

    localparam int DW = 32;
    localparam int AW = 14;
    localparam int ML = 16;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LAST0 = 2'd1;
    localparam logic [1:0] S_LAST1 = 2'd2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dm_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    dm_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_LOCK(ML)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] mem     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic          pl_we = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    // Single-port DM with registered read output.
    always @(posedge clk) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        else if (bus.dm_write) mem[bus.dm_addr] <= bus.dm_in;
        if (bus.dm_read) bus.dm_out <= mem[bus.dm_addr];
    end

    logic [DW-1:0] exp0[$];
    logic [DW-1:0] exp1[$];
    int n_chk = 0;
    int n_fail = 0;

    task automatic drive(input logic r0, input logic w0,
                         input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic r1, input logic w1,
                         input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         input logic l1);
        bus.p0_req = r0; bus.p0_we = w0; bus.p0_addr = a0; bus.p0_wdata = d0;
        bus.p1_req = r1; bus.p1_we = w1; bus.p1_addr = a1; bus.p1_wdata = d1;
        bus.p1_lock = l1;
    endtask

    task automatic idle();
        drive(0, 0, '0, '0, 0, 0, '0, '0, 0);
    endtask

    task automatic monitor();
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.p0_rvalid) begin
                    n_chk++;
                    if (exp0.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_p0: rvalid with no read pending, rdata=%h", bus.rdata);
                    end else begin
                        e = exp0.pop_front();
                        if (bus.rdata !== e) begin
                            n_fail++;
                            $display("FAIL sb_p0: rdata=%h required=%h", bus.rdata, e);
                        end
                    end
                end
                if (bus.p1_rvalid) begin
                    n_chk++;
                    if (exp1.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_p1: rvalid with no read pending, rdata=%h", bus.rdata);
                    end else begin
                        e = exp1.pop_front();
                        if (bus.rdata !== e) begin
                            n_fail++;
                            $display("FAIL sb_p1: rdata=%h required=%h", bus.rdata, e);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 0, 14'd5, '0, 1, 1, 14'd3, 32'h1, 1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            pl_we   = 1'b1;
            pl_addr = AW'(i);
            pl_data = (i == 5) ? 32'hDEADBEEF : 32'hA500_0000 + 32'(i);
            ref_mem[i] = pl_data;
        end
        @(negedge clk);
        pl_we = 1'b0;
        #1;
        n_chk++;
        if (bus.p0_gnt !== 1'b0 || bus.p1_gnt !== 1'b0 || bus.dm_read !== 1'b0 ||
            bus.dm_write !== 1'b0 || bus.p0_rvalid !== 1'b0 || bus.p1_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: gnt=%b%b rd=%b wr=%b rv=%b%b required all 0",
                     bus.p0_gnt, bus.p1_gnt, bus.dm_read, bus.dm_write, bus.p0_rvalid, bus.p1_rvalid);
        end
        n_chk++;
        if (dut.r_state !== S_IDLE || dut.r_lock_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d cnt=%0d required 0 0", dut.r_state, dut.r_lock_cnt);
        end
        idle();
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        @(negedge clk);
        drive(1, 0, 14'd5, '0, 0, 0, '0, '0, 0);
        #1;
        n_chk++;
        if (bus.p0_gnt !== 1'b1 || bus.p1_gnt !== 1'b0 || bus.dm_read !== 1'b1 ||
            bus.dm_write !== 1'b0 || bus.dm_addr !== 14'd5) begin
            n_fail++;
            $display("FAIL single_grant: gnt=%b%b rd=%b wr=%b addr=%0d required 10 1 0 5",
                     bus.p0_gnt, bus.p1_gnt, bus.dm_read, bus.dm_write, bus.dm_addr);
        end
        exp0.push_back(ref_mem[5]);
        @(negedge clk);
        n_chk++;
        if (bus.p0_rvalid !== 1'b1 || bus.p1_rvalid !== 1'b0 || bus.rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL single_rvalid: rv=%b%b rdata=%h required 10 deadbeef",
                     bus.p0_rvalid, bus.p1_rvalid, bus.rdata);
        end
        idle();
        #1;
        n_chk++;
        if (bus.p0_gnt !== 1'b0 || bus.dm_read !== 1'b0 || bus.dm_addr !== '0 || bus.dm_in !== '0) begin
            n_fail++;
            $display("FAIL no_grant_bus: gnt=%b rd=%b addr=%h in=%h required 0 0 0 0",
                     bus.p0_gnt, bus.dm_read, bus.dm_addr, bus.dm_in);
        end
        @(negedge clk);
        n_chk++;
        if (bus.p0_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_rvalid_once: rv=%b required 0", bus.p0_rvalid);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k > 0) begin
                n_chk++;
                if (bus.p0_rvalid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_rvalid[%0d]: rv=%b required 1", k, bus.p0_rvalid);
                end
            end
            drive(1, 0, AW'(k), '0, 0, 0, '0, '0, 0);
            #1;
            n_chk++;
            if (bus.p0_gnt !== 1'b1 || bus.dm_addr !== AW'(k)) begin
                n_fail++;
                $display("FAIL b2b_grant[%0d]: gnt=%b addr=%0d required 1 %0d", k, bus.p0_gnt, bus.dm_addr, k);
            end
            exp0.push_back(ref_mem[k]);
        end
        @(negedge clk);
        n_chk++;
        if (bus.p0_rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_last_rvalid: rv=%b required 1", bus.p0_rvalid);
        end
        idle();
        @(negedge clk);
    endtask

    task automatic test_write_readback();
        @(negedge clk);
        drive(0, 0, '0, '0, 1, 1, 14'd3, 32'h12345678, 0);
        #1;
        n_chk++;
        if (bus.p1_gnt !== 1'b1 || bus.p0_gnt !== 1'b0 || bus.dm_write !== 1'b1 ||
            bus.dm_read !== 1'b0 || bus.dm_addr !== 14'd3 || bus.dm_in !== 32'h12345678) begin
            n_fail++;
            $display("FAIL wr_grant: gnt=%b%b wr=%b rd=%b addr=%0d in=%h required 01 1 0 3 12345678",
                     bus.p0_gnt, bus.p1_gnt, bus.dm_write, bus.dm_read, bus.dm_addr, bus.dm_in);
        end
        ref_mem[3] = 32'h12345678;
        @(negedge clk);
        n_chk++;
        if (bus.p0_rvalid !== 1'b0 || bus.p1_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_no_rvalid: rv=%b%b required 00", bus.p0_rvalid, bus.p1_rvalid);
        end
        drive(0, 0, '0, '0, 1, 0, 14'd3, '0, 0);
        #1;
        n_chk++;
        if (bus.p1_gnt !== 1'b1 || bus.p0_gnt !== 1'b0 || bus.dm_read !== 1'b1 || bus.dm_write !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_grant: gnt=%b%b rd=%b wr=%b required 01 1 0",
                     bus.p0_gnt, bus.p1_gnt, bus.dm_read, bus.dm_write);
        end
        exp1.push_back(ref_mem[3]);
        @(negedge clk);
        n_chk++;
        if (bus.p1_rvalid !== 1'b1 || bus.p0_rvalid !== 1'b0 || bus.rdata !== 32'h12345678) begin
            n_fail++;
            $display("FAIL rd_rvalid: rv=%b%b rdata=%h required 01 12345678",
                     bus.p0_rvalid, bus.p1_rvalid, bus.rdata);
        end
        idle();
        @(negedge clk);
    endtask

    task automatic test_conflict();
        int n0;
        int n0_req;
        logic want1;
        n0 = 0;
`ifdef DM_ARB_RR_EN
        n0_req = 2;
`else
        n0_req = 4;
`endif
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1, 0, AW'(8 + k), '0, 1, 0, AW'(12 + k), '0, 0);
`ifdef DM_ARB_RR_EN
            want1 = (k % 2) == 1;
`else
            want1 = 1'b0;
`endif
            #1;
            n_chk++;
            if (bus.p0_gnt !== ~want1 || bus.p1_gnt !== want1 ||
                bus.dm_addr !== (want1 ? AW'(12 + k) : AW'(8 + k))) begin
                n_fail++;
                $display("FAIL conflict[%0d]: gnt=%b%b addr=%0d required p1=%b", k,
                         bus.p0_gnt, bus.p1_gnt, bus.dm_addr, want1);
            end
            if (bus.p0_gnt === 1'b1) n0++;
            if (want1) exp1.push_back(ref_mem[12 + k]);
            else exp0.push_back(ref_mem[8 + k]);
        end
        @(negedge clk);
        idle();
        @(negedge clk);
        n_chk++;
        if (n0 != n0_req) begin
            n_fail++;
            $display("FAIL conflict_count: p0 grants=%0d required %0d", n0, n0_req);
        end
    endtask

    task automatic test_lock_timeout();
        int  n_p1;
        logic got_p0;
        n_p1 = 0;
        got_p0 = 1'b0;
        @(negedge clk);
        drive(0, 0, '0, '0, 1, 1, 14'h40, 32'hB000_0000, 1);
        #1;
        if (bus.p1_gnt === 1'b1) begin
            ref_mem[14'h40] = 32'hB000_0000;
            n_p1 = 1;
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            drive(1, 0, 14'd5, '0, 1, 1, AW'(14'h40 + n_p1), 32'hB000_0000 + 32'(n_p1), 1);
            #1;
            if (bus.p1_gnt === 1'b1 && bus.p0_gnt === 1'b0) begin
                ref_mem[14'h40 + n_p1] = 32'hB000_0000 + 32'(n_p1);
                n_p1++;
            end else if (bus.p0_gnt === 1'b1 && bus.p1_gnt === 1'b0) begin
                got_p0 = 1'b1;
                exp0.push_back(ref_mem[5]);
                break;
            end else begin
                break;
            end
        end
        n_chk++;
        if (n_p1 != ML || got_p0 !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_timeout: p1 beats=%0d p0 granted=%b required %0d 1", n_p1, got_p0, ML);
        end
        @(negedge clk);
        idle();
        n_chk++;
        if (dut.r_state !== S_LAST0 || dut.r_lock_cnt !== '0) begin
            n_fail++;
            $display("FAIL lock_timeout_state: state=%0d cnt=%0d required %0d 0",
                     dut.r_state, dut.r_lock_cnt, S_LAST0);
        end
        @(negedge clk);
    endtask

    task automatic test_lock_saturate();
        int n_p1;
        n_p1 = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            drive(0, 0, '0, '0, 1, 0, AW'(k % 16), '0, 1);
            #1;
            if (bus.p1_gnt === 1'b1) begin
                n_p1++;
                exp1.push_back(ref_mem[k % 16]);
            end
        end
        @(negedge clk);
        n_chk++;
        if (n_p1 != 20 || dut.r_lock_cnt !== 5'(ML)) begin
            n_fail++;
            $display("FAIL lock_saturate: p1 beats=%0d cnt=%0d required 20 %0d", n_p1, dut.r_lock_cnt, ML);
        end
        drive(1, 0, 14'd6, '0, 1, 0, 14'd7, '0, 1);
        #1;
        n_chk++;
        if (bus.p0_gnt !== 1'b1 || bus.p1_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_saturate_release: gnt=%b%b required 10", bus.p0_gnt, bus.p1_gnt);
        end
        exp0.push_back(ref_mem[6]);
        @(negedge clk);
        idle();
        @(negedge clk);
    endtask

    task automatic test_lock_release();
        @(negedge clk);
        drive(0, 0, '0, '0, 1, 0, 14'd1, '0, 1);
        #1;
        n_chk++;
        if (bus.p1_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL release_beat1: p1_gnt=%b required 1", bus.p1_gnt);
        end
        exp1.push_back(ref_mem[1]);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(1, 0, 14'd2, '0, 1, 0, 14'd1, '0, 1);
            #1;
            n_chk++;
            if (bus.p1_gnt !== 1'b1 || bus.p0_gnt !== 1'b0) begin
                n_fail++;
                $display("FAIL release_locked[%0d]: gnt=%b%b required 01", k, bus.p0_gnt, bus.p1_gnt);
            end
            exp1.push_back(ref_mem[1]);
        end
        @(negedge clk);
        drive(1, 0, 14'd2, '0, 0, 0, '0, '0, 0);
        #1;
        n_chk++;
        if (bus.p0_gnt !== 1'b1 || bus.p1_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL release_p0: gnt=%b%b required 10", bus.p0_gnt, bus.p1_gnt);
        end
        exp0.push_back(ref_mem[2]);
        @(negedge clk);
        idle();
        n_chk++;
        if (dut.r_state !== S_LAST0) begin
            n_fail++;
            $display("FAIL release_state: state=%0d required %0d", dut.r_state, S_LAST0);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(0, 0, '0, '0, 1, 1, AW'(14'h60 + k), 32'hC000_0000 + 32'(k), 1);
            ref_mem[14'h60 + k] = 32'hC000_0000 + 32'(k);
        end
        @(negedge clk);
        idle();
        @(negedge clk);
        n_chk++;
        if (dut.r_state !== S_LAST1 || dut.r_lock_cnt !== '0) begin
            n_fail++;
            $display("FAIL lock_idle_exit: state=%0d cnt=%0d required %0d 0",
                     dut.r_state, dut.r_lock_cnt, S_LAST1);
        end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        drive(1, 0, 14'd5, '0, 0, 0, '0, '0, 0);
        #1;
        n_chk++;
        if (bus.p0_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_grant: p0_gnt=%b required 1", bus.p0_gnt);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_chk++;
        if (bus.p0_rvalid !== 1'b0 || bus.dm_read !== 1'b0 || bus.p0_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_async: rv=%b rd=%b gnt=%b required 0 0 0",
                     bus.p0_rvalid, bus.dm_read, bus.p0_gnt);
        end
        @(negedge clk);
        idle();
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (dut.r_state !== S_IDLE || bus.p0_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_after: state=%0d rv=%b required %0d 0",
                     dut.r_state, bus.p0_rvalid, S_IDLE);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        fork
            monitor();
        join_none
        test_reset();
        test_single_read();
        test_back_to_back();
        test_write_readback();
        test_conflict();
        test_lock_timeout();
        test_lock_saturate();
        test_lock_release();
        test_reset_mid_read();
        repeat (3) @(negedge clk);
        n_chk++;
        if (exp0.size() != 0 || exp1.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: pending p0=%0d p1=%0d required 0 0", exp0.size(), exp1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
